// File: rtl/mmv_ram_responder_pkg.sv
// mmv_ram_responder shared types and constants.
// State encoding, busy-injection LFSR constants, latency limit.
package mmv_ram_responder_pkg;

  typedef enum logic {
    st_init,
    st_run
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int RDLATENCY_MAX = 8;

endpackage

// File: rtl/mmv_ram_responder_if.sv
// mmv request/response bus between a master and the RAM responder.
// The master drives requests; the slave returns read data and busy.
interface mmv_ram_responder_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
);

  logic [AWIDTH-1:0] s_addr;
  logic              s_wreq;
  logic [DWIDTH-1:0] s_wdat;
  logic              s_rreq;
  logic [DWIDTH-1:0] s_rdat;
  logic              s_rval;
  logic              s_busy;

  modport master (
    output s_addr, s_wreq, s_wdat, s_rreq,
    input  s_rdat, s_rval, s_busy
  );

  modport slave (
    input  s_addr, s_wreq, s_wdat, s_rreq,
    output s_rdat, s_rval, s_busy
  );

endinterface

// File: rtl/mmv_ram_responder_mem.sv
// Single-port word array: synchronous write, registered read.
// The read register holds its value between reads.
module mmv_ram_responder_mem #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] addr,
  input  logic              we,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];
  logic [DWIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mmv_ram_responder.sv
// Slave memory model for the mmv bus with init sweep and address aliasing.
// MMV_RAM_RESPONDER_BUSY_INJECT_EN adds LFSR-driven random busy stalls.
module mmv_ram_responder
  import mmv_ram_responder_pkg::*;
#(
  parameter int              AWIDTH    = 8,
  parameter int              DWIDTH    = 8,
  parameter int              RDLATENCY = 2,
  parameter logic [DWIDTH-1:0] INIT_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [AWIDTH-1:0] alias_mask,
  output logic              init_done,
  mmv_ram_responder_if.slave bus
);

  if (RDLATENCY < 1 || RDLATENCY > RDLATENCY_MAX) begin : g_bad_lat
    $error("RDLATENCY out of range");
  end

  state_e               state_q, state_d;
  logic [AWIDTH-1:0]    cnt_q, cnt_d;
  logic                 init_done_q, init_done_d;
  logic                 busy_q, busy_d;
  logic [RDLATENCY-1:0] v_q, v_d;
  logic [AWIDTH-1:0]    ea, mem_addr;
  logic                 acc, wr_acc, rd_acc;
  logic                 in_init, mem_we;
  logic [DWIDTH-1:0]    mem_wdata, mem_rdata;
  logic                 stall;

`ifdef MMV_RAM_RESPONDER_BUSY_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (clear)
      lfsr_d = LFSR_SEED;
    else if (state_q == st_run)
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[2:0] == 3'b000);
`else
  assign stall = 1'b0;
`endif

  assign in_init = (state_q == st_init);
  assign ea      = bus.s_addr & ~alias_mask;
  assign acc     = (bus.s_wreq | bus.s_rreq) & ~busy_q
                 & ~in_init & ~clear;
  assign wr_acc  = acc & bus.s_wreq;
  // A simultaneous write wins; the read is dropped
  assign rd_acc  = acc & bus.s_rreq & ~bus.s_wreq;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    busy_d      = busy_q;
    if (clear) begin
      state_d     = st_init;
      cnt_d       = '0;
      init_done_d = 1'b0;
      busy_d      = 1'b1;
    end else begin
      unique case (state_q)
        st_init: begin
          cnt_d = cnt_q + AWIDTH'(1);
          if (cnt_q == '1) begin
            state_d     = st_run;
            init_done_d = 1'b1;
            busy_d      = stall;
          end
        end
        st_run:  busy_d = stall;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= st_init;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      v_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      v_q         <= v_d;
    end
  end

  assign mem_addr  = in_init ? cnt_q : ea;
  assign mem_we    = in_init | wr_acc;
  assign mem_wdata = in_init ? INIT_WORD : bus.s_wdat;

  mmv_ram_responder_mem #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (mem_wdata),
    .re    (rd_acc),
    .rdata (mem_rdata)
  );

  // Stage 0 data lives in the memory read register
  always_comb begin
    v_d = '0;
    if (!clear) begin
      v_d[0] = rd_acc;
      for (int i = 1; i < RDLATENCY; i++)
        v_d[i] = v_q[i-1];
    end
  end

  if (RDLATENCY > 1) begin : g_dpipe
    logic [DWIDTH-1:0] d_q [RDLATENCY-1];
    logic [DWIDTH-1:0] d_d [RDLATENCY-1];

    always_comb begin
      d_d[0] = (v_q[0] && !clear) ? mem_rdata : d_q[0];
      for (int i = 1; i < RDLATENCY-1; i++)
        d_d[i] = (v_q[i] && !clear) ? d_q[i-1] : d_q[i];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) d_q <= '{default: '0};
      else       d_q <= d_d;
    end

    assign bus.s_rdat = d_q[RDLATENCY-2];
  end else begin : g_dnopipe
    assign bus.s_rdat = mem_rdata;
  end

  assign bus.s_rval = v_q[RDLATENCY-1];
  assign bus.s_busy = busy_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_mmv_ram_responder.sv
// Directed bench for mmv_ram_responder (AWIDTH=8, DWIDTH=8, RDLATENCY=2).
// Random busy-injection traffic runs when the inject macro is defined.
module tb_mmv_ram_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [7:0] alias_mask;
  logic       init_done;

  int n_vec  = 0;
  int n_miss = 0;

  mmv_ram_responder_if #(.AWIDTH(8), .DWIDTH(8)) bus ();

  mmv_ram_responder #(
    .AWIDTH    (8),
    .DWIDTH    (8),
    .RDLATENCY (2),
    .INIT_WORD (8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .alias_mask (alias_mask),
    .init_done  (init_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rdy();
    int k = 0;
    while (bus.s_busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) chk("ready_timeout", 1, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.s_addr = a;
    bus.s_wdat = d;
    bus.s_wreq = 1'b1;
    wait_rdy();
    @(negedge clk);
    bus.s_wreq = 1'b0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [7:0] a,
                        input logic [7:0] exp);
    bus.s_addr = a;
    bus.s_rreq = 1'b1;
    wait_rdy();
    @(negedge clk);
    bus.s_rreq = 1'b0;
    chk({tag, "_early"}, bus.s_rval, 0);
    @(negedge clk);
    chk({tag, "_rval"}, bus.s_rval, 1);
    chk({tag, "_rdat"}, bus.s_rdat, exp);
  endtask

  // Counts busy cycles from the current sample; no rval may appear
  task automatic busy_win(input string tag);
    int n = 0;
    int rv = 0;
    while (bus.s_busy && n < 1000) begin
      if (init_done) chk({tag, "_early_done"}, 1, 0);
      if (bus.s_rval) rv++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cyc"}, n, 256);
    chk({tag, "_done"}, init_done, 1);
    chk({tag, "_rval_in_init"}, rv, 0);
  endtask

  initial begin
    reset      = 1'b1;
    clear      = 1'b0;
    alias_mask = '0;
    bus.s_addr = '0;
    bus.s_wreq = 1'b0;
    bus.s_wdat = '0;
    bus.s_rreq = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.s_busy, 1);
    chk("rst_rval", bus.s_rval, 0);
    chk("rst_rdat", bus.s_rdat, 0);
    chk("rst_done", init_done, 0);
    reset = 1'b0;
    busy_win("init");

`ifndef MMV_RAM_RESPONDER_BUSY_INJECT_EN
    rd_chk("rd37", 8'h37, 8'h00);

    wr(8'h10, 8'h5A);
    rd_chk("raw10", 8'h10, 8'h5A);
    @(negedge clk);
    chk("hold_rval", bus.s_rval, 0);
    chk("hold_rdat", bus.s_rdat, 8'h5A);

    for (int i = 1; i <= 4; i++)
      wr(8'(i), 8'(8'h11 * i));
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        bus.s_addr = 8'(k + 1);
        bus.s_rreq = 1'b1;
      end else begin
        bus.s_rreq = 1'b0;
      end
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        chk($sformatf("b2b_rval%0d", k), bus.s_rval, 1);
        chk($sformatf("b2b_rdat%0d", k), bus.s_rdat,
            8'(8'h11 * k));
      end else begin
        chk($sformatf("b2b_idle%0d", k), bus.s_rval, 0);
      end
    end

    alias_mask = 8'h04;
    wr(8'h00, 8'hAA);
    wr(8'h04, 8'h55);
    rd_chk("alias00", 8'h00, 8'h55);
    alias_mask = 8'h00;
    rd_chk("noalias04", 8'h04, 8'h44);

    bus.s_addr = 8'h30;
    bus.s_wdat = 8'h99;
    bus.s_wreq = 1'b1;
    bus.s_rreq = 1'b1;
    @(negedge clk);
    bus.s_wreq = 1'b0;
    bus.s_rreq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wr_rd_drop%0d", k), bus.s_rval, 0);
      @(negedge clk);
    end
    rd_chk("wr_rd30", 8'h30, 8'h99);

    wr(8'h20, 8'h77);
    bus.s_addr = 8'h20;
    bus.s_rreq = 1'b1;
    @(negedge clk);
    bus.s_rreq = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_kill", bus.s_rval, 0);
    busy_win("clr");
    rd_chk("clr20", 8'h20, 8'h00);
`else
    begin
      logic [7:0] sh [256];
      logic [7:0] q [$];
      int cyc = 0;
      int bcyc = 0;
      int ops = 0;
      logic drv = 1'b0;
      logic was_busy = 1'b1;
      logic is_wr = 1'b0;
      logic [7:0] ra = '0;
      logic [7:0] rdv = '0;
      foreach (sh[i]) sh[i] = 8'h00;
      while (ops < 1000 && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (bus.s_rval) begin
          if (q.size() == 0) chk("rand_extra_rval", 1, 0);
          else chk("rand_rdat", bus.s_rdat, q.pop_front());
        end
        if (drv && !was_busy) begin
          ops++;
          if (is_wr) sh[ra] = rdv;
          else       q.push_back(sh[ra]);
          drv = 1'b0;
        end
        if (!drv && ops < 1000) begin
          is_wr = 1'($urandom_range(0, 1));
          ra    = 8'($urandom_range(0, 31));
          rdv   = 8'($urandom);
          bus.s_addr = ra;
          bus.s_wdat = rdv;
          bus.s_wreq = is_wr;
          bus.s_rreq = ~is_wr;
          drv = 1'b1;
        end else if (!drv) begin
          bus.s_wreq = 1'b0;
          bus.s_rreq = 1'b0;
        end
        was_busy = bus.s_busy;
        if (bus.s_busy) bcyc++;
      end
      bus.s_wreq = 1'b0;
      bus.s_rreq = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (bus.s_rval) begin
          if (q.size() == 0) chk("rand_extra_rval", 1, 0);
          else chk("rand_rdat", bus.s_rdat, q.pop_front());
        end
      end
      chk("rand_ops", ops, 1000);
      chk("rand_q_empty", q.size(), 0);
      chk("busy_duty", (bcyc * 100 >= 8 * cyc) &&
                       (bcyc * 100 <= 17 * cyc), 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mmv_ram_responder.md
# mmv_ram_responder

Slave-side memory model for the mmv request/response bus: accepts single-word write and read requests, stores data in an internal 2**AWIDTH-word array and returns read data after a fixed latency. Sits at the far end of bus masters such as RAM testers and bridges in simulation and on-chip self-test setups, and can deliberately alias address lines so that address-bus tests have a real fault to detect.

## Interface
- AWIDTH, 8: address width; array depth 2**AWIDTH words
- DWIDTH, 8: data width
- RDLATENCY, 2: read latency in cycles, legal range 1..8
- INIT_WORD, '0: value written to every word by the init sweep
- reset  in  1  reset, asynchronous, active-high
- clk  in  1  clock clk
- clear  in  1  synchronous restart: flush reads, re-run init sweep
- alias_mask  in  AWIDTH  address bits forced to 0 before array access (fault injection)
- init_done  out  1  high once the init sweep has completed
- s_addr  in  AWIDTH  request address
- s_wreq  in  1  write request
- s_wdat  in  DWIDTH  write data
- s_rreq  in  1  read request
- s_rdat  out  DWIDTH  read data, valid with s_rval
- s_rval  out  1  read response strobe, one cycle per accepted read
- s_busy  out  1  request not accepted this cycle

## Operation
- FSM states: st_init (sweep), st_run.
- Reset or clear -> st_init with sweep counter 0. Each cycle: word[cnt] <= INIT_WORD, cnt++. After word 2**AWIDTH-1 -> st_run, init_done <= 1.
- In st_init: s_busy = 1 and no requests are accepted.
- Accept: (s_wreq | s_rreq) & ~s_busy in st_run.
- Effective address ea = s_addr & ~alias_mask, evaluated in the accept cycle.
- Accepted write: word[ea] <= s_wdat at that edge.
- Accepted read: word[ea] is captured and pushed into the read pipeline.
- s_wreq & s_rreq in the same cycle: the write is performed and the read is dropped (no s_rval).
- A read accepted one cycle after a write to the same ea returns the new data.
- Read pipeline: RDLATENCY-stage shift of {valid, data}.
  - It is never full, so reads never cause backpressure.
  - It keeps shifting while s_busy is high, so responses in flight are still delivered.
- clear:
  - Zeroes all pipeline valid bits, so responses in flight are lost.
  - Clears init_done and restarts the sweep.
  - Array contents are overwritten by the sweep.
- reset mid-operation: same as clear, asynchronously.
- alias_mask may change at any time. A change affects only requests accepted after it.

## Timing
- Reset values: s_busy 1, s_rval 0, s_rdat 0, init_done 0.
- Init sweep takes exactly 2**AWIDTH cycles from the first clk edge after reset release (or after the clear cycle). s_busy falls in the same cycle init_done rises.
- Read accepted at edge N: s_rval = 1 and s_rdat valid during the cycle after edge N+RDLATENCY-1, i.e. RDLATENCY cycles after the accept cycle.
- s_rdat holds its last value when s_rval = 0.
- Throughput: one request per cycle when s_busy = 0.
- s_busy is registered. A master that sees s_busy high must hold the request stable.

## Configuration
- MMV_RAM_RESPONDER_BUSY_INJECT_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) advances every cycle in st_run.
  - s_busy is registered from lfsr[2:0] == 3'b000, giving about 1/8 stall cycles.
  - The LFSR reloads its seed on reset and on clear.
- Undefined: no LFSR; s_busy = 0 throughout st_run.

## Structure
- Package mmv_ram_responder_pkg:
  - state enum
  - LFSR_SEED, LFSR_TAPS
  - RDLATENCY_MAX = 8
- Sub-module mmv_ram_responder_mem: single-port synchronous-write array with registered read, shared by the sweep and the bus port. The sweep and the bus are never active in the same cycle.
- The read pipeline, FSM and busy logic stay in the top module.

## Test plan
Bench parameters: AWIDTH=8, DWIDTH=8, RDLATENCY=2, INIT_WORD=8'h00, macro undefined unless stated.
- Reset release -> s_busy high for exactly 256 cycles; init_done rises with s_busy falling; a read of 8'h37 returns 8'h00.
- Write 8'h5A @ 8'h10, then read @ 8'h10 in the next cycle -> s_rval exactly 2 cycles after the read accept, s_rdat = 8'h5A.
- Back-to-back reads @ 8'h01..8'h04 holding 8'h11..8'h44 -> four consecutive s_rval pulses carrying 8'h11, 8'h22, 8'h33, 8'h44 in order.
- alias_mask = 8'h04; write 8'hAA @ 8'h00, then write 8'h55 @ 8'h04 -> a read @ 8'h00 returns 8'h55.
- Read accepted, then clear asserted the next cycle -> no s_rval for that read; s_busy high for 256 cycles; the written location returns 8'h00 afterwards.
- Macro defined; 1000 random writes and reads -> no request accepted while s_busy = 1; busy duty between 8% and 17%; every read returns the last data written to that address.
